// File: rtl/bp_tanh.sv
// Backprop and weight update for one tanh neuron.
// A single shared fixed-point multiplier is time-multiplexed over an 8-state FSM.
module bp_tanh #(
    parameter int NUM = 2,
    parameter int WIDTH = 32,
    parameter int FRAC = 24,
    parameter logic [WIDTH-1:0] LR = 32'h0080_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [WIDTH-1:0]       i_err,
    input  logic [WIDTH-1:0]       i_a,
    input  logic [NUM*WIDTH-1:0]   i_x,
    input  logic [NUM*WIDTH-1:0]   i_w,
    input  logic [WIDTH-1:0]       i_b,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_wr,
    output logic [NUM*WIDTH-1:0]   o_w,
    output logic [WIDTH-1:0]       o_b,
    output logic [WIDTH-1:0]       o_delta,
    output logic [NUM*WIDTH-1:0]   o_dx
);

    localparam int KW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int WW = 2 * WIDTH;
    localparam logic signed [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
    localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WW-1:0] MAXW = WW'(MAXV);
    localparam logic signed [WW-1:0] MINW = WW'(MINV);

    typedef enum logic [2:0] {IDLE, SQ, DLT, BIAS, GW, UW, PX, WR} state_t;

    state_t state, state_nx;
    logic [KW-1:0] k;
    logic last;
    logic signed [WIDTH-1:0] err_r, a_r, b_r, sq_r, delta_r, dw_r, bn_r;
    logic signed [WIDTH-1:0] x_r [NUM];
    logic signed [WIDTH-1:0] w_r [NUM];
    logic signed [WIDTH-1:0] wn_r [NUM];
    logic signed [WIDTH-1:0] dx_r [NUM];
    logic signed [WIDTH-1:0] m_a, m_b, m_res;
    logic signed [WW-1:0] prod, shf;

    function automatic logic signed [WIDTH-1:0] sat_sub(
        input logic signed [WIDTH-1:0] p,
        input logic signed [WIDTH-1:0] q
    );
        logic signed [WIDTH:0] s;
        s = {p[WIDTH-1], p} - {q[WIDTH-1], q};
        if (s[WIDTH] != s[WIDTH-1])
            return s[WIDTH] ? MINV : MAXV;
        return s[WIDTH-1:0];
    endfunction

    assign last = (k == KW'(NUM - 1));

    // Operand select for the one shared multiplier
    always_comb begin
        m_a = '0;
        m_b = '0;
        case (state)
            SQ:   begin m_a = a_r;     m_b = a_r;                 end
            DLT:  begin m_a = err_r;   m_b = sat_sub(ONE, sq_r);  end
            BIAS: begin m_a = LR;      m_b = delta_r;             end
            GW:   begin m_a = delta_r; m_b = x_r[k];              end
            UW:   begin m_a = LR;      m_b = dw_r;                end
            PX:   begin m_a = delta_r; m_b = w_r[k];              end
            default: ;
        endcase
        prod = WW'(m_a) * WW'(m_b);
        shf = prod >>> FRAC;
        if (shf > MAXW)
            m_res = MAXV;
        else if (shf < MINW)
            m_res = MINV;
        else
            m_res = shf[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        o_busy = (state != IDLE);
        o_wr = 1'b0;
        o_done = 1'b0;
        case (state)
            IDLE: if (i_start) state_nx = SQ;
            SQ:   state_nx = DLT;
            DLT:  state_nx = BIAS;
            BIAS: state_nx = GW;
            GW:   state_nx = UW;
            UW:   state_nx = PX;
            PX:   state_nx = last ? WR : GW;
            WR: begin
                state_nx = IDLE;
                o_wr = 1'b1;
                o_done = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
            err_r <= '0;
            a_r <= '0;
            b_r <= '0;
            sq_r <= '0;
            delta_r <= '0;
            dw_r <= '0;
            bn_r <= '0;
            for (int i = 0; i < NUM; i++) begin
                x_r[i] <= '0;
                w_r[i] <= '0;
                wn_r[i] <= '0;
                dx_r[i] <= '0;
            end
            o_w <= '0;
            o_b <= '0;
            o_delta <= '0;
            o_dx <= '0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    err_r <= i_err;
                    a_r <= i_a;
                    b_r <= i_b;
                    k <= '0;
                    for (int i = 0; i < NUM; i++) begin
                        x_r[i] <= i_x[i*WIDTH +: WIDTH];
                        w_r[i] <= i_w[i*WIDTH +: WIDTH];
                    end
                end
                SQ:   sq_r <= m_res;
                DLT:  delta_r <= m_res;
                BIAS: bn_r <= sat_sub(b_r, m_res);
                GW:   dw_r <= m_res;
                UW:   wn_r[k] <= sat_sub(w_r[k], m_res);
                PX: begin
                    dx_r[k] <= m_res;
                    // Publish everything together so WR shows a coherent result
                    if (last) begin
                        for (int i = 0; i < NUM; i++) begin
                            o_w[i*WIDTH +: WIDTH] <= wn_r[i];
                            o_dx[i*WIDTH +: WIDTH] <=
                                (KW'(i) == k) ? m_res : dx_r[i];
                        end
                        o_b <= bn_r;
                        o_delta <= delta_r;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_tanh.sv
// Directed bench for bp_tanh: latency, arithmetic, saturation,
// reset abort, and back-to-back passes with i_start held high.
module tb_bp_tanh;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [31:0] i_err, i_a, i_b;
    logic [63:0] i_x, i_w;
    logic        o_busy, o_done, o_wr;
    logic [63:0] o_w, o_dx;
    logic [31:0] o_b, o_delta;

    int n_cmp = 0;
    int n_bad = 0;

    int wr_cyc, wr_cnt, done_cnt;
    logic busy1;
    logic [63:0] cap_w, cap_dx;
    logic [31:0] cap_b, cap_delta;

    bp_tanh dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_err(i_err), .i_a(i_a), .i_x(i_x), .i_w(i_w), .i_b(i_b),
        .o_busy(o_busy), .o_done(o_done), .o_wr(o_wr),
        .o_w(o_w), .o_b(o_b), .o_delta(o_delta), .o_dx(o_dx)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic [31:0] err, a, b,
                          input logic [63:0] x, w);
        i_err = err;
        i_a = a;
        i_b = b;
        i_x = x;
        i_w = w;
    endtask

    // Pulse start for one cycle, then watch ncyc cycles
    task automatic run_pass(input int ncyc);
        wr_cyc = -1;
        wr_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        i_start = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (n == 1) begin
                i_start = 1'b0;
                busy1 = o_busy;
            end
            if (o_done) done_cnt++;
            if (o_wr) begin
                wr_cnt++;
                if (wr_cyc < 0) wr_cyc = n;
                cap_w = o_w;
                cap_b = o_b;
                cap_delta = o_delta;
                cap_dx = o_dx;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        i_start = 1'b0;
        set_in(32'h0, 32'h0, 32'h0, 64'h0, 64'h0);
        #12;
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy got %b want 0", o_busy);
        end
        n_cmp++;
        if ({o_wr, o_done} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_wr_done got %b want 00", {o_wr, o_done});
        end
        n_cmp++;
        if ({o_w, o_dx, o_b, o_delta} !== 192'h0) begin
            n_bad++;
            $display("FAIL reset_outs got %h want 0",
                     {o_w, o_dx, o_b, o_delta});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        set_in(32'h0100_0000, 32'h0, 32'h0,
               {32'h0200_0000, 32'h0100_0000},
               {32'h0080_0000, 32'h0080_0000});
        run_pass(14);
        n_cmp++;
        if (busy1 !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_busy got %b want 1", busy1);
        end
        n_cmp++;
        if (wr_cyc !== 10 || wr_cnt !== 1 || done_cnt !== 1) begin
            n_bad++;
            $display("FAIL basic_latency got cyc=%0d wr=%0d done=%0d want 10/1/1",
                     wr_cyc, wr_cnt, done_cnt);
        end
        n_cmp++;
        if (cap_delta !== 32'h0100_0000) begin
            n_bad++;
            $display("FAIL basic_delta got %h want 01000000", cap_delta);
        end
        n_cmp++;
        if (cap_w !== {32'hFF80_0000, 32'h0000_0000}) begin
            n_bad++;
            $display("FAIL basic_w got %h want ff80000000000000", cap_w);
        end
        n_cmp++;
        if (cap_b !== 32'hFF80_0000) begin
            n_bad++;
            $display("FAIL basic_b got %h want ff800000", cap_b);
        end
        n_cmp++;
        if (cap_dx !== {32'h0080_0000, 32'h0080_0000}) begin
            n_bad++;
            $display("FAIL basic_dx got %h want 0080000000800000", cap_dx);
        end
        n_cmp++;
        if (o_w !== {32'hFF80_0000, 32'h0000_0000}) begin
            n_bad++;
            $display("FAIL basic_hold got %h want ff80000000000000", o_w);
        end
    endtask

    task automatic test_a_one;
        set_in(32'h0030_0000, 32'h0100_0000, 32'h0012_3456,
               {32'h0100_0000, 32'hFF00_0000},
               {32'hFFC0_0000, 32'h0040_0000});
        run_pass(13);
        n_cmp++;
        if (wr_cyc !== 10 || wr_cnt !== 1) begin
            n_bad++;
            $display("FAIL aone_latency got cyc=%0d wr=%0d want 10/1",
                     wr_cyc, wr_cnt);
        end
        n_cmp++;
        if (cap_delta !== 32'h0) begin
            n_bad++;
            $display("FAIL aone_delta got %h want 0", cap_delta);
        end
        n_cmp++;
        if (cap_w !== {32'hFFC0_0000, 32'h0040_0000}) begin
            n_bad++;
            $display("FAIL aone_w got %h want ffc0000000400000", cap_w);
        end
        n_cmp++;
        if (cap_b !== 32'h0012_3456 || cap_dx !== 64'h0) begin
            n_bad++;
            $display("FAIL aone_b_dx got b=%h dx=%h want 00123456/0",
                     cap_b, cap_dx);
        end
    endtask

    task automatic test_saturate;
        set_in(32'hFF00_0000, 32'h0, 32'h0,
               {32'h0, 32'h0100_0000},
               {32'h0, 32'h7FFF_0000});
        run_pass(13);
        n_cmp++;
        if (cap_w !== {32'h0, 32'h7FFF_FFFF}) begin
            n_bad++;
            $display("FAIL sat_w got %h want 000000007fffffff", cap_w);
        end
        n_cmp++;
        if (cap_b !== 32'h0080_0000 || cap_delta !== 32'hFF00_0000) begin
            n_bad++;
            $display("FAIL sat_b_delta got b=%h d=%h want 00800000/ff000000",
                     cap_b, cap_delta);
        end
        n_cmp++;
        if (cap_dx !== {32'h0, 32'h8001_0000}) begin
            n_bad++;
            $display("FAIL sat_dx got %h want 0000000080010000", cap_dx);
        end
    endtask

    task automatic test_reset_abort;
        int cnt;
        cnt = 0;
        set_in(32'h0100_0000, 32'h0, 32'h0,
               {32'h0200_0000, 32'h0100_0000},
               {32'h0080_0000, 32'h0080_0000});
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_busy got %b want 0", o_busy);
        end
        n_cmp++;
        if ({o_w, o_dx, o_b, o_delta} !== 192'h0) begin
            n_bad++;
            $display("FAIL abort_outs got %h want 0",
                     {o_w, o_dx, o_b, o_delta});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (o_wr || o_done) cnt++;
        end
        n_cmp++;
        if (cnt !== 0) begin
            n_bad++;
            $display("FAIL abort_pulse got %0d pulses want 0", cnt);
        end
    endtask

    task automatic test_rst_start;
        int cnt;
        cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rststart_busy got %b want 0", o_busy);
        end
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (o_wr) cnt++;
        end
        n_cmp++;
        if (cnt !== 0) begin
            n_bad++;
            $display("FAIL rststart_wr got %0d want 0", cnt);
        end
    endtask

    task automatic test_back_to_back;
        int wc [3];
        int cnt;
        logic busy11;
        logic [63:0] w1, w2, hold_w;
        logic [31:0] b2;
        cnt = 0;
        busy11 = 1'bx;
        w1 = 'x;
        w2 = 'x;
        b2 = 'x;
        hold_w = 'x;
        for (int i = 0; i < 3; i++) wc[i] = -1;
        set_in(32'h0100_0000, 32'h0, 32'h0,
               {32'h0200_0000, 32'h0100_0000},
               {32'h0080_0000, 32'h0080_0000});
        @(negedge clk);
        i_start = 1'b1;
        for (int n = 1; n <= 26; n++) begin
            @(negedge clk);
            if (o_wr) begin
                if (cnt < 3) wc[cnt] = n;
                if (cnt == 0) w1 = o_w;
                if (cnt == 1) begin
                    w2 = o_w;
                    b2 = o_b;
                end
                cnt++;
            end
            if (n == 11) busy11 = o_busy;
            if (n == 15) hold_w = o_w;
            if (n == 2)
                set_in(32'hFF00_0000, 32'h0, 32'h0,
                       {32'h0, 32'h0100_0000},
                       {32'h0, 32'h7FFF_0000});
            if (n == 21) i_start = 1'b0;
        end
        n_cmp++;
        if (cnt !== 2 || wc[0] !== 10 || wc[1] !== 21) begin
            n_bad++;
            $display("FAIL b2b_wr got n=%0d at %0d,%0d want 2 at 10,21",
                     cnt, wc[0], wc[1]);
        end
        n_cmp++;
        if (busy11 !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle got %b want 0", busy11);
        end
        n_cmp++;
        if (w1 !== {32'hFF80_0000, 32'h0000_0000}) begin
            n_bad++;
            $display("FAIL b2b_w1 got %h want ff80000000000000", w1);
        end
        n_cmp++;
        if (hold_w !== {32'hFF80_0000, 32'h0000_0000}) begin
            n_bad++;
            $display("FAIL b2b_hold got %h want ff80000000000000", hold_w);
        end
        n_cmp++;
        if (w2 !== {32'h0, 32'h7FFF_FFFF} || b2 !== 32'h0080_0000) begin
            n_bad++;
            $display("FAIL b2b_w2 got w=%h b=%h want 000000007fffffff/00800000",
                     w2, b2);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_a_one;
        test_saturate;
        test_reset_abort;
        test_rst_start;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bp_tanh.md
BP_TANH -- requirements
Module: bp_tanh

Interface
REQ-001 SHALL have parameter NUM, default 2, meaning the number of neuron inputs and weights.
REQ-002 SHALL have parameter WIDTH, default 32, meaning the signed fixed-point word width.
REQ-003 SHALL have parameter FRAC, default 24, meaning the number of fractional bits; ONE = 1<<FRAC.
REQ-004 SHALL have parameter LR, default 32'h0080_0000, meaning the learning rate in the same fixed-point format (0.5 at the defaults).
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock; reset rst, asynchronous, active-high; clock clk.
- rst  in  1  asynchronous active-high reset.
- i_start  in  1  request one backprop/update pass.
- i_err  in  WIDTH  error term dE/da for this neuron.
- i_a  in  WIDTH  forward tanh activation.
- i_x  in  NUM*WIDTH  forward inputs; element k at [k*WIDTH +: WIDTH].
- i_w  in  NUM*WIDTH  current weights, same packing as i_x.
- i_b  in  WIDTH  current bias.
- o_busy  out  1  pass in progress.
- o_done  out  1  one-cycle completion pulse.
- o_wr  out  1  one-cycle write strobe to the forward neuron's weight store.
- o_w  out  NUM*WIDTH  updated weights.
- o_b  out  WIDTH  updated bias.
- o_delta  out  WIDTH  delta = err*(1-a^2).
- o_dx  out  NUM*WIDTH  back-propagated error, delta*w_old[k].

Function
REQ-006 SHALL use a single shared signed multiplier: full 2*WIDTH product, arithmetic shift right by FRAC (floor), saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; this is called fmul.
REQ-007 SHALL saturate all add/subtract results to the signed WIDTH range.
REQ-008 SHALL use FSM states IDLE, SQ, DLT, BIAS, GW, UW, PX, WR, with one state per clock cycle.
REQ-009 In IDLE, i_start=1 SHALL latch i_err, i_a, i_x, i_w, i_b into working registers, clear index k to 0, and go to SQ; inputs are ignored thereafter until the next IDLE.
REQ-010 SQ SHALL compute sq = fmul(a,a); go to DLT.
REQ-011 DLT SHALL compute delta = fmul(err, sat(ONE - sq)); go to BIAS.
REQ-012 BIAS SHALL compute b_new = sat(b - fmul(LR, delta)); go to GW.
REQ-013 GW SHALL compute dw = fmul(delta, x[k]); go to UW.
REQ-014 UW SHALL compute w_new[k] = sat(w[k] - fmul(LR, dw)); go to PX.
REQ-015 PX SHALL compute dx[k] = fmul(delta, w_old[k]); if k = NUM-1 go to WR, else increment k and go to GW.
REQ-016 WR SHALL last one cycle and assert o_wr=1 and o_done=1 in that cycle; o_w, o_b, o_delta and o_dx SHALL all present new values in that same cycle; the next state is IDLE.
REQ-017 Latency SHALL be fixed: start accepted in cycle t gives the WR cycle at t+4+3*NUM (t+10 at NUM=2).
REQ-018 o_w, o_b, o_delta and o_dx SHALL be held constant from one WR until the next WR; no intermediate values SHALL be visible on them.
REQ-019 o_busy SHALL be 1 in every state except IDLE.
REQ-020 i_start while o_busy=1 SHALL be ignored, with no queuing.
REQ-021 i_start in the cycle immediately after WR SHALL be accepted, giving a back-to-back pass.
REQ-022 Weights SHALL be written only via the o_wr pulse; o_wr SHALL never assert outside WR.

Reset
REQ-023 rst=1 SHALL force IDLE, k=0, and all outputs and working registers to 0, regardless of clock.
REQ-024 Reset during any non-IDLE state SHALL abort the pass with no o_wr or o_done pulse.
REQ-025 If rst and i_start are simultaneous, reset SHALL win and the start SHALL be lost.

Verification
REQ-026 The bench SHALL cover: a=0, err=0x01000000, x={0x01000000,0x02000000}, w={0x00800000,0x00800000}, b=0 -> at t+10: o_delta=0x01000000, o_w={0x00000000,0xFF800000}, o_b=0xFF800000, o_dx={0x00800000,0x00800000}, o_wr=o_done=1 for one cycle.
REQ-027 The bench SHALL cover: a=0x01000000, any err -> o_delta=0, o_w=i_w, o_b=i_b, o_dx=0, and o_wr still pulses at t+10.
REQ-028 The bench SHALL cover: a=0, err=0xFF000000, x0=0x01000000, w0=0x7FFF0000 -> o_w[0]=0x7FFFFFFF (saturated).
REQ-029 The bench SHALL cover: rst asserted at t+5 -> o_busy=0 and all outputs 0 immediately, and no o_wr/o_done pulse afterwards.
REQ-030 The bench SHALL cover: i_start held high continuously -> passes accepted at t and t+11 only, o_wr at t+10 and t+21, and input changes during busy have no effect on results.
